// File: rtl/hdmi_timing_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_timing_pkg
// Shared timing constants, widths and types for the HDMI frame sequencer.
//   - DEF_* : 640x480@60 default video timing
//   - COUNTER_W / PAT_W : raster counter and pattern-select widths
//   - seq_state_e : pattern sequencer FSM states
//   - strobe_t : bundle of the three raster strobes carried down the delay chain
//   - calc_total() : active + porches + sync for one axis
// -----------------------------------------------------------------------------
package hdmi_timing_pkg;

    localparam int COUNTER_W = 10;
    localparam int PAT_W     = 2;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic {
        ST_AUTO = 1'b0,
        ST_HOLD = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic draw;
        logic hs;
        logic vs;
    } strobe_t;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/hdmi_pattern_seq.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_seq
// Pattern-select sequencer. Advances pattern_sel only on a frame wrap, either
// automatically every FRAMES_PER_PATTERN frames (AUTO) or on a latched operator
// request (both modes). Several requests within a frame, or a request landing
// on the same wrap as an auto-advance, give a single step.
// Ports:
//   pixclk      in  pixel clock
//   rst_n       in  synchronous active-low reset
//   wrap        in  last pixel of the frame (X==H_TOTAL-1 && Y==V_TOTAL-1)
//   hold        in  1 = HOLD (auto-advance frozen), 0 = AUTO
//   next        in  single-cycle advance request
//   pattern_sel out current pattern index
// -----------------------------------------------------------------------------
module hdmi_pattern_seq
    import hdmi_timing_pkg::*;
#(
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int NUM_PATTERNS       = 4
) (
    input  logic             pixclk,
    input  logic             rst_n,
    input  logic             wrap,
    input  logic             hold,
    input  logic             next,
    output logic [PAT_W-1:0] pattern_sel
);

    localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

    seq_state_e       state_q, state_d;
    logic [FC_W-1:0]  count_q, count_d;
    logic             pending_q, pending_d;
    logic [PAT_W-1:0] pat_q, pat_d;

    logic auto_mode;
    logic req_adv, auto_adv, advance;

    // State register
    always_ff @(posedge pixclk) begin
        if (!rst_n) state_q <= ST_AUTO;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_AUTO: if (hold)  state_d = ST_HOLD;
            ST_HOLD: if (!hold) state_d = ST_AUTO;
            default:            state_d = ST_AUTO;
        endcase
    end

    // FSM outputs
    always_comb begin
        auto_mode = (state_q == ST_AUTO);
    end

    // Datapath: a request on the wrap cycle itself is honoured directly and
    // never lands in pending, so it cannot cause a second step next frame.
    always_comb begin
        req_adv   = wrap & (pending_q | next);
        auto_adv  = wrap & auto_mode & (count_q == FC_LAST);
        advance   = req_adv | auto_adv;

        pending_d = pending_q;
        if (req_adv)   pending_d = 1'b0;
        else if (next) pending_d = 1'b1;

        // HOLD parks the count at 0, which also gives the clear on HOLD->AUTO.
        count_d = count_q;
        if (!auto_mode || advance) count_d = '0;
        else if (wrap)             count_d = count_q + 1'b1;

        pat_d = pat_q;
        if (advance) pat_d = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
    end

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            count_q   <= '0;
            pending_q <= 1'b0;
            pat_q     <= '0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            pat_q     <= pat_d;
        end
    end

    assign pattern_sel = pat_q;

endmodule

// File: rtl/hdmi_frame_sequencer.sv
// -----------------------------------------------------------------------------
// hdmi_frame_sequencer
// Video timing and pattern sequencing for the HDMI pattern generator.
// Raster counters are the zero-latency timebase; draw/sync strobes are decoded
// from them and delayed PIPE_LAT cycles to line up with the registered colour.
// frame_start and pattern_sel are registered on the wrap edge so both are
// valid together with pixel (0,0).
// Ports:
//   pixclk       in  pixel clock
//   rst_n        in  synchronous active-low reset
//   hold         in  1 = HOLD pattern, 0 = AUTO advance
//   next         in  single-cycle pattern advance request
//   CounterX     out horizontal position 0..H_TOTAL-1
//   CounterY     out vertical position 0..V_TOTAL-1
//   draw_area    out active video enable (PIPE_LAT delayed)
//   hsync        out horizontal sync (PIPE_LAT delayed)
//   vsync        out vertical sync (PIPE_LAT delayed)
//   frame_start  out one-cycle pulse at CounterX==0 && CounterY==0
//   pattern_sel  out current pattern index
// -----------------------------------------------------------------------------
module hdmi_frame_sequencer
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE           = DEF_H_ACTIVE,
    parameter int H_FP               = DEF_H_FP,
    parameter int H_SYNC             = DEF_H_SYNC,
    parameter int H_BP               = DEF_H_BP,
    parameter int V_ACTIVE           = DEF_V_ACTIVE,
    parameter int V_FP               = DEF_V_FP,
    parameter int V_SYNC             = DEF_V_SYNC,
    parameter int V_BP               = DEF_V_BP,
    parameter bit HS_POL             = 1'b0,
    parameter bit VS_POL             = 1'b0,
    parameter int PIPE_LAT           = 1,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int NUM_PATTERNS       = 4
) (
    input  logic                 pixclk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 next,
    output logic [COUNTER_W-1:0] CounterX,
    output logic [COUNTER_W-1:0] CounterY,
    output logic                 draw_area,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start,
    output logic [PAT_W-1:0]     pattern_sel
);

    localparam int H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [COUNTER_W-1:0] X_LAST = COUNTER_W'(H_TOTAL - 1);
    localparam logic [COUNTER_W-1:0] Y_LAST = COUNTER_W'(V_TOTAL - 1);
    localparam strobe_t STROBE_IDLE = '{draw: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("hdmi_frame_sequencer: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
        $error("hdmi_frame_sequencer: PIPE_LAT must be >= 1");
    end
    if (NUM_PATTERNS < 2 || NUM_PATTERNS > 4 || FRAMES_PER_PATTERN < 1) begin : g_bad_pat
        $error("hdmi_frame_sequencer: bad NUM_PATTERNS or FRAMES_PER_PATTERN");
    end

    logic [COUNTER_W-1:0] x_q, x_d;
    logic [COUNTER_W-1:0] y_q, y_d;
    logic                 line_end, wrap;
    logic                 frame_start_q, frame_start_d;
    strobe_t              strobe_now;
    strobe_t              pipe_q [PIPE_LAT:1];
    strobe_t              pipe_d [PIPE_LAT:1];

    // Raster counters
    always_comb begin
        line_end = (x_q == X_LAST);
        wrap     = line_end && (y_q == Y_LAST);
        x_d      = line_end ? '0 : x_q + 1'b1;
        y_d      = y_q;
        if (line_end) y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        frame_start_d = wrap;
    end

    // Strobe decode from the current counters; vsync follows Y alone so its
    // edges fall on X==0 before the delay chain.
    always_comb begin
        strobe_now.draw = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
        strobe_now.hs   = ((int'(x_q) >= HS_START) && (int'(x_q) < HS_END)) ? HS_POL : ~HS_POL;
        strobe_now.vs   = ((int'(y_q) >= VS_START) && (int'(y_q) < VS_END)) ? VS_POL : ~VS_POL;
    end

    // Delay chain: stage 1 captures the decode, stage PIPE_LAT drives the pins
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[1] = strobe_now;
        for (int i = 2; i <= PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            for (int i = 1; i <= PIPE_LAT; i++) pipe_q[i] <= STROBE_IDLE;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            pipe_q        <= pipe_d;
        end
    end

    hdmi_pattern_seq #(
        .FRAMES_PER_PATTERN (FRAMES_PER_PATTERN),
        .NUM_PATTERNS       (NUM_PATTERNS)
    ) u_pattern_seq (
        .pixclk      (pixclk),
        .rst_n       (rst_n),
        .wrap        (wrap),
        .hold        (hold),
        .next        (next),
        .pattern_sel (pattern_sel)
    );

    assign CounterX    = x_q;
    assign CounterY    = y_q;
    assign draw_area   = pipe_q[PIPE_LAT].draw;
    assign hsync       = pipe_q[PIPE_LAT].hs;
    assign vsync       = pipe_q[PIPE_LAT].vs;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hdmi_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hdmi_frame_sequencer
// Directed bench on a shrunken raster (16x10, frame = 160 clocks), PIPE_LAT=2,
// two frames per pattern, four patterns.
// -----------------------------------------------------------------------------
module tb_hdmi_frame_sequencer;

    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;   // 16
    localparam int VT = VA + VFP + VSW + VBP;   // 10
    localparam int FRAME = HT * VT;             // 160

    logic       pixclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       hold   = 1'b0;
    logic       next   = 1'b0;
    logic [9:0] CounterX, CounterY;
    logic       draw_area, hsync, vsync, frame_start;
    logic [1:0] pattern_sel;

    int total = 0;
    int bad   = 0;

    // Expected raster state, tracked independently from the DUT
    int         ex = 0, ey = 0;
    logic [2:0] eh1 = 3'b011, eh2 = 3'b011;     // {draw,hs,vs} delay stages
    logic       efs = 1'b0;

    int pat_exp [1:8] = '{0, 1, 1, 2, 2, 3, 3, 0};

    always #5 pixclk = ~pixclk;

    hdmi_frame_sequencer #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL (1'b0), .VS_POL (1'b0), .PIPE_LAT (2),
        .FRAMES_PER_PATTERN (2), .NUM_PATTERNS (4)
    ) dut (
        .pixclk      (pixclk),
        .rst_n       (rst_n),
        .hold        (hold),
        .next        (next),
        .CounterX    (CounterX),
        .CounterY    (CounterY),
        .draw_area   (draw_area),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .pattern_sel (pattern_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; expected strobes come from the pre-edge expected position.
    task automatic tick();
        logic [2:0] now_s;
        logic       r;
        r        = rst_n;
        now_s[2] = (ex < HA) && (ey < VA);
        now_s[1] = !((ex >= HA + HFP) && (ex < HA + HFP + HSW));
        now_s[0] = !((ey >= VA + VFP) && (ey < VA + VFP + VSW));
        @(posedge pixclk);
        #1;
        if (!r) begin
            ex = 0; ey = 0; eh1 = 3'b011; eh2 = 3'b011; efs = 1'b0;
        end else begin
            efs = (ex == HT - 1) && (ey == VT - 1);
            eh2 = eh1;
            eh1 = now_s;
            if (ex == HT - 1) begin
                ex = 0;
                ey = (ey == VT - 1) ? 0 : ey + 1;
            end else begin
                ex++;
            end
        end
        chk("counter_x",   32'(CounterX), 32'(ex));
        chk("counter_y",   32'(CounterY), 32'(ey));
        chk("strobes",     32'({draw_area, hsync, vsync}), 32'(eh2));
        chk("frame_start", 32'(frame_start), 32'(efs));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_next();
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    // Run to the next frame_start; pattern_sel must hold pat_before until then
    // and show pat_after on the (0,0) cycle.
    task automatic run_frame(input string tag, input int pat_before,
                             input int pat_after, input int period);
        int n;
        n = 0;
        while (n < 2 * FRAME) begin
            tick();
            n++;
            if (frame_start === 1'b1) break;
            chk({tag, "_steady"}, 32'(pattern_sel), 32'(pat_before));
        end
        chk({tag, "_fs_seen"}, 32'(frame_start), 32'd1);
        chk({tag, "_pat"},     32'(pattern_sel), 32'(pat_after));
        chk({tag, "_origin"},  32'({CounterX, CounterY}), 32'd0);
        if (period != 0) chk({tag, "_period"}, 32'(n), 32'(period));
    endtask

    task automatic seek(input int x, input int y);
        int n;
        n = 0;
        while (!(CounterX == 10'(x) && CounterY == 10'(y)) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("seek_reached", 32'(n < 2 * FRAME), 32'd1);
    endtask

    initial begin
        int nd, nh, nv;

        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_pat", 32'(pattern_sel), 32'd0);
            chk("rst_sync", 32'({hsync, vsync}), 32'b11);
        end
        rst_n = 1'b1;
        tick();
        chk("first_x", 32'(CounterX), 32'd1);
        chk("first_y", 32'(CounterY), 32'd0);

        // First frame_start one full frame after release
        run_frame("f1", 0, 0, FRAME - 1);

        // One whole frame of strobe statistics
        nd = 0; nh = 0; nv = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (draw_area) nd++;
            if (!hsync)    nh++;
            if (!vsync)    nv++;
        end
        chk("draw_per_frame",  32'(nd), 32'd48);
        chk("hsync_per_frame", 32'(nh), 32'd30);
        chk("vsync_per_frame", 32'(nv), 32'd32);
        chk("f2_fs",  32'(frame_start), 32'd1);
        chk("f2_pat", 32'(pattern_sel), 32'(pat_exp[2]));

        // AUTO: a step every second frame, wrapping 3 -> 0
        for (int k = 3; k <= 8; k++) run_frame("auto", pat_exp[k-1], pat_exp[k], FRAME);

        // HOLD: three requests in one frame give one step, then nothing
        hold = 1'b1;
        ticks(3);
        pulse_next();
        ticks(5);
        pulse_next();
        ticks(5);
        pulse_next();
        run_frame("hold_next", 0, 1, 0);
        for (int k = 0; k < 5; k++) run_frame("hold_keep", 1, 1, FRAME);

        // Back to AUTO with a cleared count: first wrap does not advance
        hold = 1'b0;
        run_frame("auto_resume", 1, 1, FRAME);

        // Request on the very wrap edge where the auto-advance is also due
        seek(HT - 1, VT - 1);
        pulse_next();
        chk("sim_fs",  32'(frame_start), 32'd1);
        chk("sim_pat", 32'(pattern_sel), 32'd2);
        run_frame("sim_after1", 2, 2, FRAME);
        run_frame("sim_after2", 2, 3, FRAME);

        // Pending request coinciding with due auto-advance: single step
        run_frame("cnt_up", 3, 3, FRAME);
        ticks(10);
        pulse_next();
        run_frame("pend_auto", 3, 0, 0);

        // Pending request with count 0: step and count stays cleared
        ticks(10);
        pulse_next();
        run_frame("pend_clr", 0, 1, 0);
        run_frame("pend_clr2", 1, 1, FRAME);

        // Mid-frame reset while count is 1 and pattern is 1
        seek(5, 3);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_pat", 32'(pattern_sel), 32'd0);
        chk("mid_rst_xy",  32'({CounterX, CounterY}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_flush", 32'({draw_area, hsync, vsync}), 32'b011);
        run_frame("post_rst", 0, 0, FRAME - 1);
        run_frame("post_rst2", 0, 1, FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_frame_sequencer.md
Name: hdmi_frame_sequencer

Overview:
- Video timing and pattern-sequencing controller that drives the HDMI frame pattern generator.
- Produces the 10-bit CounterX/CounterY raster counters, the sync and data-enable strobes delayed to match the generator's registered colour output, and a pattern select.
- The pattern select advances every N frames (AUTO) or on operator request (HOLD), and changes only at frame boundaries.
- Sits between the pixel-clock domain root and the pattern generator / TMDS encoders in the HDMI generator.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- PIPE_LAT, 1, cycles from counters to aligned strobes (>=1; matches colour register depth)
- FRAMES_PER_PATTERN, 120, frames per pattern in AUTO mode (>=1)
- NUM_PATTERNS, 4, number of patterns (2..4)

Ports:
- pixclk  in  1  pixel clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- hold  in  1  level; 1 = HOLD mode (auto-advance frozen), 0 = AUTO
- next  in  1  single-cycle request to advance the pattern at the next frame boundary
- CounterX  out  10  horizontal position, 0..H_TOTAL-1
- CounterY  out  10  vertical position, 0..V_TOTAL-1
- draw_area  out  1  active-video enable, delayed PIPE_LAT
- hsync  out  1  horizontal sync, delayed PIPE_LAT
- vsync  out  1  vertical sync, delayed PIPE_LAT
- frame_start  out  1  one-cycle pulse coincident with CounterX==0 && CounterY==0
- pattern_sel  out  2  current pattern index, 0..NUM_PATTERNS-1

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be <=1024 (elaboration check).
- Reset (rst_n=0 at a posedge) sets:
  - CounterX=0, CounterY=0
  - draw_area=0, hsync=~HS_POL, vsync=~VS_POL; every delay stage likewise
  - frame_start=0, pattern_sel=0, frame count=0, pending=0, FSM=AUTO
- Reset applied mid-frame takes effect on the same edge, with no partial-line completion.
- Counters:
  - Each non-reset edge increments CounterX. At H_TOTAL-1 it wraps to 0 and CounterY increments.
  - CounterY wraps to 0 at V_TOTAL-1 when CounterX wraps.
  - First edge after reset release gives CounterX 0->1, so the first frame_start occurs after one full frame.
- Strobes:
  - Computed from the current counters, then passed through a PIPE_LAT-deep register chain.
  - draw_area=1 iff X<H_ACTIVE && Y<V_ACTIVE.
  - hsync=HS_POL iff H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC.
  - vsync=VS_POL iff V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC. vsync transitions align to X=0.
- wrap event: X==H_TOTAL-1 && Y==V_TOTAL-1. On that edge, frame_start is registered to 1 and pattern_sel is updated, so the new pattern_sel is valid with pixel (0,0).
- Pattern FSM, sub-module hdmi_pattern_seq; states AUTO and HOLD:
  - AUTO -> HOLD when hold=1 (sampled every cycle). HOLD -> AUTO when hold=0; frame count clears to 0 on that transition.
  - AUTO: frame count increments on each wrap. At wrap with count==FRAMES_PER_PATTERN-1, pattern_sel advances and count returns to 0.
  - HOLD: frame count is held at 0; pattern_sel advances only via next.
  - next sets the pending flag. At wrap with pending (or next asserted that same cycle), pattern_sel advances, pending clears, and the frame count clears.
  - Multiple next pulses within one frame collapse into a single advance.
  - In AUTO, a pending advance and an auto-advance due at the same wrap produce one increment, not two.
  - pattern_sel advance: pattern_sel==NUM_PATTERNS-1 -> 0; otherwise +1.
- Latency summary:
  - Counters: 0 cycles, the reference timebase.
  - draw_area/hsync/vsync: PIPE_LAT cycles.
  - frame_start and pattern_sel: aligned to the counters.

Decomposition:
- Package hdmi_timing_pkg holds:
  - 640x480@60 default timing constants
  - COUNTER_W=10, PAT_W=2
  - the FSM state typedef (AUTO, HOLD)
  - a function computing totals
- Sub-module hdmi_pattern_seq contains the frame counter, pending flag, FSM and pattern_sel register. Its inputs are wrap, hold, next and rst_n.
- The raster counters and strobe delay chain stay in the top level.

Test Plan:
1. Reset check: hold rst_n=0 for 5 cycles, then release -> all outputs at reset values during reset. CounterX=1, CounterY=0 after the first edge. hsync and vsync are high (POL=0).
2. Raster timing: run defaults for 2 frames -> 800 cycles/line, 525 lines. hsync low exactly 96 cycles starting X=656 (+1 cycle latency). vsync low on lines 490-491. draw_area high 640 cycles/line, 307200 per frame. frame_start period 420000.
3. AUTO sequencing: run with FRAMES_PER_PATTERN=2 -> pattern_sel steps 0,1,2,3,0 at successive even frame_starts, changing only at (0,0).
4. HOLD with next: hold=1, three next pulses within one frame -> exactly one increment at the next frame_start. No further change over 5 more frames.
5. Simultaneous next and wrap: next asserted on the wrap edge, in AUTO with count==FPP-1 -> single increment, count=0.
6. Mid-frame reset: rst_n=0 at X=300, Y=200 -> next edge gives counters 0,0, pattern_sel=0, strobe chain flushed to the inactive state.
